// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: turns byte/half/word accesses into full-word
// memory traffic, with a read-modify-write pass for sub-word stores.
module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic [31:0]       rdata,
    output logic              rvalid,
    output logic              misaligned,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic {IDLE, MERGE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-3:0]   word_addr_q;
    logic [1:0]          lane_q;
    logic                half_q;
    logic [31:0]         merge_word_q;
    logic [15:0]         wdata_q;
    logic [31:0]         rdata_q;
    logic                rvalid_q;
    logic                misaligned_q;

    logic                is_word, is_half, aligned, in_idle;
    logic                load_fire, misalign_fire, word_store, start_merge;
    logic [7:0]          byte_sel;
    logic [15:0]         half_sel;
    logic [31:0]         load_val;
    logic [31:0]         merged;

    // Size 11 behaves as a word access.
    assign is_word = size[1];
    assign is_half = (size == 2'b01);
    assign aligned = is_word ? (addr[1:0] == 2'b00) :
                     is_half ? ~addr[0] : 1'b1;

    assign in_idle       = (state_q == IDLE);
    assign load_fire     = in_idle && req && !we && aligned;
    assign misalign_fire = in_idle && req && !aligned;
    assign word_store    = in_idle && req && we && aligned && is_word;
    assign start_merge   = in_idle && req && we && aligned && !is_word;

    assign byte_sel = mem_rdata[{addr[1:0], 3'b000} +: 8];
    assign half_sel = mem_rdata[{addr[1], 4'b0000} +: 16];

    always_comb begin
        load_val = mem_rdata;
        if (!is_word) begin
            if (is_half)
                load_val = {{16{~uns & half_sel[15]}}, half_sel};
            else
                load_val = {{24{~uns & byte_sel[7]}}, byte_sel};
        end
    end

    // Replace the latched target lane(s) with store data; other lanes keep the read word.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic hit;
            assign hit = half_q ? (lane_q[1] == LANE[1]) : (lane_q == LANE);
            assign merged[8*gi +: 8] = !hit ? merge_word_q[8*gi +: 8] :
                                       half_q ? wdata_q[8*(gi%2) +: 8] : wdata_q[7:0];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_merge) state_d = MERGE;
            MERGE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy      = start_merge;
    assign mem_we    = rst_n && ((state_q == MERGE) || word_store);
    assign mem_addr  = (state_q == MERGE) ? {word_addr_q, 2'b00} : {addr[ADDR_W-1:2], 2'b00};
    assign mem_wdata = (state_q == MERGE) ? merged : wdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            word_addr_q  <= '0;
            lane_q       <= '0;
            half_q       <= 1'b0;
            merge_word_q <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rvalid_q     <= load_fire;
            misaligned_q <= misalign_fire;
            if (load_fire)
                rdata_q <= load_val;
            if (start_merge) begin
                word_addr_q  <= addr[ADDR_W-1:2];
                lane_q       <= addr[1:0];
                half_q       <= is_half;
                merge_word_q <= mem_rdata;
                wdata_q      <= wdata[15:0];
            end
        end
    end

    assign rdata      = rdata_q;
    assign rvalid     = rvalid_q;
    assign misaligned = misaligned_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus random traffic against a
// byte-addressed memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we, uns;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        busy, rvalid, misaligned, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [64];
    logic [7:0]  model_b [256];
    logic [31:0] exp_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .uns(uns),
        .addr(addr), .wdata(wdata), .busy(busy), .rdata(rdata), .rvalid(rvalid),
        .misaligned(misaligned), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic ok_align(input logic [1:0] sz, input logic [31:0] a);
        return (a % nbytes(sz)) == 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic u, input logic [31:0] a);
        int n = nbytes(sz);
        logic [31:0] v = 0;
        for (int i = 0; i < n; i++) v = v | (32'(model_b[(a + i) % 256]) << (8 * i));
        if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    // One transaction, started at a negative edge; returns at the negative edge after completion.
    task automatic op(input logic w, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] d);
        logic al = ok_align(sz, a);
        logic sub_store = w && al && (nbytes(sz) < 4);
        req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
        #1;
        $display("op we=%0d size=%0d uns=%0d addr=%h wdata=%h", w, sz, u, a, d);
        check("busy", 32'(busy), 32'(sub_store));
        check("mem_addr", mem_addr, {a[31:2], 2'b00});
        if (sub_store) begin
            check("rmw_read_we", 32'(mem_we), 0);
            @(posedge clk); @(negedge clk);
            check("merge_busy", 32'(busy), 0);
            check("merge_we", 32'(mem_we), 1);
            check("merge_addr", mem_addr, {a[31:2], 2'b00});
        end else begin
            check("mem_we", 32'(mem_we), 32'(w && al));
        end
        @(posedge clk); @(negedge clk);
        req = 1'b0;
        if (!w && al) exp_rdata = model_load(sz, u, a);
        if (w && al)
            for (int i = 0; i < nbytes(sz); i++) model_b[(a + i) % 256] = d[8*i +: 8];
        check("rvalid", 32'(rvalid), 32'(!w && al));
        check("misaligned", 32'(misaligned), 32'(!al));
        check("rdata", rdata, exp_rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        for (int i = 0; i < 256; i++) model_b[i] = 8'h0;
        exp_rdata = 32'h0;
        rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0;
        addr = 32'h0; wdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rdata", rdata, 0);
        check("rst_rvalid", 32'(rvalid), 0);
        check("rst_misaligned", 32'(misaligned), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        rst_n = 1'b1;

        // Word store / load, then sub-word merge into it
        op(1, 2'b10, 0, 32'h10, 32'h11223344);
        op(0, 2'b10, 0, 32'h10, 32'h0);
        check("lw_0x10", rdata, 32'h11223344);
        op(1, 2'b00, 0, 32'h11, 32'h000000AA);
        op(0, 2'b10, 0, 32'h10, 32'h0);
        check("sb_merge", rdata, 32'h1122AA44);

        // Extension cases
        op(1, 2'b10, 0, 32'h20, 32'h00008080);
        op(0, 2'b00, 0, 32'h20, 32'h0);
        check("lb", rdata, 32'hFFFFFF80);
        op(0, 2'b00, 1, 32'h20, 32'h0);
        check("lbu", rdata, 32'h00000080);
        op(0, 2'b01, 0, 32'h20, 32'h0);
        check("lh", rdata, 32'hFFFF8080);
        op(0, 2'b01, 1, 32'h22, 32'h0);
        check("lhu", rdata, 32'h00000000);

        // Misaligned accesses leave memory and rdata alone
        op(1, 2'b01, 0, 32'h23, 32'hBEEF);
        op(0, 2'b10, 0, 32'h22, 32'h0);
        check("mis_mem", mem[8], 32'h00008080);

        // Reset asserted during MERGE aborts the write
        req = 1'b1; we = 1'b1; size = 2'b00; uns = 1'b0; addr = 32'h30; wdata = 32'h55;
        @(posedge clk); @(negedge clk);
        check("rst_merge_busy", 32'(busy), 0);
        rst_n = 1'b0; req = 1'b0;
        #1;
        check("rst_merge_we", 32'(mem_we), 0);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        exp_rdata = 32'h0;
        check("rst_merge_rdata", rdata, 0);
        check("rst_merge_rvalid", 32'(rvalid), 0);
        check("rst_merge_mis", 32'(misaligned), 0);
        check("rst_merge_mem", mem[12], 32'h0);
        op(0, 2'b10, 0, 32'h30, 32'h0);

        // Back-to-back sub-word stores
        op(1, 2'b00, 0, 32'h40, 32'h01);
        op(1, 2'b00, 0, 32'h41, 32'h02);
        check("b2b_mem", mem[16], 32'h00000201);

        // Random traffic
        for (int n = 0; n < 150; n++) begin
            op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               32'($urandom_range(0, 255)), $urandom);
        end

        for (int i = 0; i < 64; i++)
            check("final_mem", mem[i], {model_b[4*i+3], model_b[4*i+2], model_b[4*i+1], model_b[4*i]});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
